// File: rtl/ws2812_pkg.sv
// ws2812_pkg: shared states, 50 MHz timing defaults, colour order and pixel scaling helpers
package ws2812_pkg;
  typedef enum logic [2:0] {IDLE, FETCH, LOAD, SEND, LATCH} state_e;
  typedef enum logic {ORD_GRB = 1'b0, ORD_RGB = 1'b1} order_e;
  localparam int T0H_DEF = 20;
  localparam int T1H_DEF = 40;
  localparam int BIT_DEF = 63;
  localparam int RST_DEF = 15000;
  function automatic int addr_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  function automatic logic [7:0] scale(input logic [7:0] c, input logic [7:0] b);
    logic [15:0] p;
    p = {8'd0, c} * ({8'd0, b} + 16'd1);
    return p[15:8];
  endfunction
  function automatic logic [23:0] wire_word(input logic [23:0] rgb, input logic [7:0] b, input order_e o);
    logic [7:0] r, g, bl;
    r = scale(rgb[23:16], b);
    g = scale(rgb[15:8], b);
    bl = scale(rgb[7:0], b);
    return o == ORD_RGB ? {r, g, bl} : {g, r, bl};
  endfunction
endpackage

// File: rtl/ws2812_strip_drv_if.sv
// ws2812_strip_drv_if: frame control, pixel-memory read port and strip output of the driver
interface ws2812_strip_drv_if #(parameter int NUM_LEDS = 64) ();
  localparam int AW = ws2812_pkg::addr_w(NUM_LEDS);
  logic start;
  logic [7:0] brightness;
  logic order_rgb;
  logic pix_rd_en;
  logic [AW-1:0] pix_addr;
  logic [23:0] pix_rgb;
  logic busy;
  logic frame_done;
  logic led_data;
  modport master (input start, brightness, order_rgb, pix_rgb, output pix_rd_en, pix_addr, busy, frame_done, led_data);
  modport slave (output start, brightness, order_rgb, pix_rgb, input pix_rd_en, pix_addr, busy, frame_done, led_data);
endinterface

// File: rtl/ws2812_bit_tx.sv
// ws2812_bit_tx: one bit period; high for T1H/T0H clocks then low, bit_done in the final clock
module ws2812_bit_tx #(
  parameter int T0H_CYC = 20,
  parameter int T1H_CYC = 40,
  parameter int BIT_CYC = 63
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic din,
  output logic dout,
  output logic bit_done
);
  localparam int CW = $clog2(BIT_CYC);
  logic [CW-1:0] cnt, th;
  logic active;
  assign bit_done = active && cnt == CW'(BIT_CYC - 1);
  // load wins over bit_done so back-to-back bits have no gap
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      th <= '0;
      active <= 1'b0;
      dout <= 1'b0;
    end else if (load) begin
      cnt <= '0;
      th <= din ? CW'(T1H_CYC) : CW'(T0H_CYC);
      active <= 1'b1;
      dout <= 1'b1;
    end else if (bit_done) begin
      active <= 1'b0;
      dout <= 1'b0;
    end else if (active) begin
      cnt <= cnt + 1'b1;
      dout <= cnt + 1'b1 < th;
    end
endmodule

// File: rtl/ws2812_strip_drv.sv
// ws2812_strip_drv: reads NUM_LEDS pixels, scales and serialises them to a WS2812 strip, then latches
module ws2812_strip_drv import ws2812_pkg::*; #(
  parameter int NUM_LEDS = 64,
  parameter int T0H_CYC = T0H_DEF,
  parameter int T1H_CYC = T1H_DEF,
  parameter int BIT_CYC = BIT_DEF,
  parameter int RST_CYC = RST_DEF
) (
  input logic sys_clk,
  input logic sys_rst,
  ws2812_strip_drv_if.master bus
);
  localparam int AW = addr_w(NUM_LEDS);
  localparam logic [AW-1:0] LAST = AW'(NUM_LEDS - 1);
  localparam int LW = $clog2(RST_CYC + 1);
  state_e state;
  order_e ord;
  logic [7:0] br;
  logic [AW-1:0] pix;
  logic [4:0] bidx;
  logic [23:0] sh, stage, word;
  logic [LW-1:0] lcnt;
  logic fetch_q, load, ld_bit, bit_done, last_bit, last_pix;
  assign word = wire_word(bus.pix_rgb, br, ord);
  assign last_bit = bidx == 5'd23;
  assign last_pix = pix == LAST;
  assign load = state == LOAD || (state == SEND && bit_done && !(last_bit && last_pix));
  assign ld_bit = state == LOAD ? word[23] : last_bit ? stage[23] : sh[22];
  ws2812_bit_tx #(.T0H_CYC(T0H_CYC), .T1H_CYC(T1H_CYC), .BIT_CYC(BIT_CYC)) u_tx (
    .clk(sys_clk), .rst(sys_rst), .load(load), .din(ld_bit), .dout(bus.led_data), .bit_done(bit_done)
  );
  always_ff @(posedge sys_clk or posedge sys_rst)
    if (sys_rst) begin
      state <= IDLE;
      ord <= ORD_GRB;
      br <= '0;
      pix <= '0;
      bidx <= '0;
      sh <= '0;
      stage <= '0;
      lcnt <= '0;
      fetch_q <= 1'b0;
      bus.pix_rd_en <= 1'b0;
      bus.pix_addr <= '0;
      bus.busy <= 1'b0;
      bus.frame_done <= 1'b0;
    end else begin
      fetch_q <= bus.pix_rd_en;
      if (fetch_q) stage <= word;
      case (state)
        IDLE: if (bus.start) begin
          state <= FETCH;
          br <= bus.brightness;
          ord <= order_e'(bus.order_rgb);
          pix <= '0;
          bus.busy <= 1'b1;
          bus.pix_rd_en <= 1'b1;
          bus.pix_addr <= '0;
        end
        FETCH: begin
          bus.pix_rd_en <= 1'b0;
          state <= LOAD;
        end
        LOAD: begin
          sh <= word;
          bidx <= '0;
          bus.pix_rd_en <= NUM_LEDS > 1;
          if (NUM_LEDS > 1) bus.pix_addr <= bus.pix_addr + 1'b1;
          state <= SEND;
        end
        SEND: begin
          bus.pix_rd_en <= 1'b0;
          if (bit_done) begin
            if (!last_bit) begin
              sh <= sh << 1;
              bidx <= bidx + 1'b1;
            end else if (!last_pix) begin
              // entering the next pixel: prefetch the one after it, if any
              sh <= stage;
              bidx <= '0;
              pix <= pix + 1'b1;
              bus.pix_rd_en <= bus.pix_addr != LAST;
              if (bus.pix_addr != LAST) bus.pix_addr <= bus.pix_addr + 1'b1;
            end else begin
              state <= LATCH;
              lcnt <= '0;
              bus.frame_done <= RST_CYC == 1;
            end
          end
        end
        LATCH: begin
          lcnt <= lcnt + 1'b1;
          bus.frame_done <= lcnt == LW'(RST_CYC - 2);
          if (lcnt == LW'(RST_CYC - 1)) begin
            state <= IDLE;
            bus.busy <= 1'b0;
            bus.frame_done <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_ws2812_strip_drv.sv
// tb_ws2812_strip_drv: directed frames on a 2-LED and a 1-LED driver against per-cycle expected waveforms
module tb_ws2812_strip_drv;
  typedef struct {int c; logic led; logic fd;} ent_t;
  logic clk, rst;
  int cyc = 0, checks = 0, errors = 0, sa = 0, sb = 0;
  logic [23:0] mem [2];
  ent_t qa[$], qb[$];
  int aq[$];
  ws2812_strip_drv_if #(.NUM_LEDS(2)) ia ();
  ws2812_strip_drv_if #(.NUM_LEDS(1)) ib ();
  ws2812_strip_drv #(.NUM_LEDS(2), .T0H_CYC(20), .T1H_CYC(40), .BIT_CYC(63), .RST_CYC(200)) dut_a (
    .sys_clk(clk), .sys_rst(rst), .bus(ia.master)
  );
  ws2812_strip_drv #(.NUM_LEDS(1), .T0H_CYC(2), .T1H_CYC(4), .BIT_CYC(6), .RST_CYC(10)) dut_b (
    .sys_clk(clk), .sys_rst(rst), .bus(ib.master)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [23:0] exp_word(input logic [23:0] rgb, input int br, input bit rgb_order);
    int c [3];
    for (int k = 0; k < 3; k++) c[k] = (int'(rgb[23-8*k -: 8]) * (br + 1)) / 256;
    return rgb_order ? {8'(c[0]), 8'(c[1]), 8'(c[2])} : {8'(c[1]), 8'(c[0]), 8'(c[2])};
  endfunction
  task automatic push_frame(input bit sel, input int s, input int n, input int t0, input int t1,
                            input int bc, input int rc, input logic [23:0] w0, input logic [23:0] w1, output int d);
    ent_t e;
    logic [23:0] w;
    int base;
    base = s + 3;
    for (int p = 0; p < n; p++) begin
      w = p == 0 ? w0 : w1;
      for (int i = 0; i < 24; i++)
        for (int t = 0; t < bc; t++) begin
          e.c = base + (p * 24 + i) * bc + t;
          e.led = t < (w[23-i] ? t1 : t0);
          e.fd = 1'b0;
          if (sel) qb.push_back(e); else qa.push_back(e);
        end
    end
    base = base + n * 24 * bc;
    for (int t = 0; t < rc; t++) begin
      e.c = base + t;
      e.led = 1'b0;
      e.fd = t == rc - 1;
      if (sel) qb.push_back(e); else qa.push_back(e);
    end
    d = base + rc - 1;
  endtask
  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask
  task automatic start_a(input logic [7:0] b, input logic o, output int s, output int d);
    ia.brightness = b;
    ia.order_rgb = o;
    ia.start = 1'b1;
    s = cyc;
    sa = 0;
    aq.push_back(0);
    aq.push_back(1);
    push_frame(1'b0, s, 2, 20, 40, 63, 200, exp_word(mem[0], int'(b), o), exp_word(mem[1], int'(b), o), d);
    @(negedge clk);
    ia.start = 1'b0;
    chk("a_rd_first", ia.pix_rd_en, 1);
    chk("a_addr_first", 32'(ia.pix_addr), 0);
    chk("a_busy_start", ia.busy, 1);
  endtask
  task automatic finish_a(input int d);
    wait_until(d);
    chk("a_busy_last", ia.busy, 1);
    @(negedge clk);
    chk("a_busy_fall", ia.busy, 0);
    chk("a_done_clear", ia.frame_done, 0);
    chk("a_strobes", sa, 2);
    chk("a_drain", qa.size(), 0);
  endtask
  initial begin
    ent_t e;
    forever begin
      @(negedge clk);
      if (ia.pix_rd_en) begin
        sa++;
        chk("a_addr", 32'(ia.pix_addr), aq.size() > 0 ? aq.pop_front() : 32'hdead);
      end
      if (qa.size() > 0 && qa[0].c == cyc) begin
        e = qa.pop_front();
        chk("a_led", ia.led_data, e.led);
        chk("a_frame_done", ia.frame_done, e.fd);
      end
    end
  end
  initial begin
    ent_t e;
    forever begin
      @(negedge clk);
      if (ib.pix_rd_en) sb++;
      if (qb.size() > 0 && qb[0].c == cyc) begin
        e = qb.pop_front();
        chk("b_led", ib.led_data, e.led);
        chk("b_frame_done", ib.frame_done, e.fd);
      end
    end
  end
  // pixel memory for dut_a: data one cycle after the strobe, filler otherwise
  initial begin
    logic r, a;
    forever begin
      @(negedge clk);
      r = ia.pix_rd_en;
      a = ia.pix_addr;
      @(posedge clk);
      #1;
      ia.pix_rgb = r ? mem[a] : 24'h5A5A5A;
    end
  end
  initial begin
    int s, d;
    rst = 1'b1;
    ia.start = 1'b0;
    ia.brightness = 8'd0;
    ia.order_rgb = 1'b0;
    ia.pix_rgb = 24'h0;
    ib.start = 1'b0;
    ib.brightness = 8'd0;
    ib.order_rgb = 1'b0;
    ib.pix_rgb = 24'hC35A0F;
    repeat (3) @(negedge clk);
    chk("rst_led", ia.led_data, 0);
    chk("rst_busy", ia.busy, 0);
    chk("rst_done", ia.frame_done, 0);
    chk("rst_rd", ia.pix_rd_en, 0);
    chk("rst_addr", 32'(ia.pix_addr), 0);
    chk("rst_b_led", ib.led_data, 0);
    rst = 1'b0;
    @(negedge clk);
    mem[0] = 24'hFF0000;
    mem[1] = 24'h00FF00;
    start_a(8'd255, 1'b0, s, d);
    finish_a(d);
    @(negedge clk);
    start_a(8'd255, 1'b1, s, d);
    finish_a(d);
    @(negedge clk);
    mem[0] = 24'h808080;
    mem[1] = 24'h808080;
    start_a(8'd127, 1'b0, s, d);
    finish_a(d);
    @(negedge clk);
    mem[0] = 24'hFF0000;
    mem[1] = 24'h00FF00;
    start_a(8'd255, 1'b0, s, d);
    wait_until(s + 500);
    ia.start = 1'b1;
    ia.brightness = 8'd0;
    ia.order_rgb = 1'b1;
    @(negedge clk);
    ia.start = 1'b0;
    wait_until(d - 50);
    ia.start = 1'b1;
    @(negedge clk);
    ia.start = 1'b0;
    finish_a(d);
    repeat (5) @(negedge clk);
    chk("a_no_requeue", ia.busy, 0);
    start_a(8'd255, 1'b0, s, d);
    wait_until(s + 3 + 24 * 63 + 10);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_led", ia.led_data, 0);
    chk("abort_busy", ia.busy, 0);
    qa.delete();
    aq.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    start_a(8'd255, 1'b0, s, d);
    finish_a(d);
    @(negedge clk);
    ib.brightness = 8'd255;
    ib.start = 1'b1;
    s = cyc;
    sb = 0;
    push_frame(1'b1, s, 1, 2, 4, 6, 10, exp_word(24'hC35A0F, 255, 1'b0), 24'h0, d);
    @(negedge clk);
    ib.start = 1'b0;
    chk("b_rd_first", ib.pix_rd_en, 1);
    wait_until(d);
    chk("b_busy_last", ib.busy, 1);
    @(negedge clk);
    chk("b_busy_fall", ib.busy, 0);
    chk("b_strobes", sb, 1);
    chk("b_drain", qb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ws2812_strip_drv.md
WS2812_STRIP_DRV -- requirements
Module: ws2812_strip_drv

Interface
REQ-001 SHALL have parameter NUM_LEDS, default 64: LEDs per frame, range 1..1024.
REQ-002 SHALL have parameter T0H_CYC, default 20: high time of a 0-bit, in clocks.
REQ-003 SHALL have parameter T1H_CYC, default 40: high time of a 1-bit, in clocks.
REQ-004 SHALL have parameter BIT_CYC, default 63: total bit period, in clocks; must exceed T1H_CYC.
REQ-005 SHALL have parameter RST_CYC, default 15000: low latch gap after the last bit, in clocks.
REQ-006 SHALL use one clock; reset is asynchronous and active-high.
REQ-007 sys_clk  in  1  system clock.
REQ-008 sys_rst  in  1  asynchronous active-high reset.
REQ-009 start  in  1  single-cycle frame request.
REQ-010 brightness  in  8  global scale; sampled at accepted start.
REQ-011 order_rgb  in  1  0 = GRB wire order, 1 = RGB; sampled at accepted start.
REQ-012 pix_rd_en  out  1  pixel-memory read strobe.
REQ-013 pix_addr  out  AW=max(1,clog2(NUM_LEDS))  pixel index.
REQ-014 pix_rgb  in  24  {R,G,B}; valid exactly 1 cycle after pix_rd_en.
REQ-015 busy  out  1  high from accepted start through end of latch gap.
REQ-016 frame_done  out  1  one-cycle pulse at end of latch gap.
REQ-017 led_data  out  1  registered serial line to the strip.

Function
REQ-018 FSM SHALL have states IDLE, FETCH, LOAD, SEND, LATCH.
- IDLE->FETCH on start.
- FETCH->LOAD after 1 cycle.
- LOAD->SEND after 1 cycle.
- SEND->LATCH after bit 23 of pixel NUM_LEDS-1.
- LATCH->IDLE after RST_CYC cycles.
REQ-019 start SHALL be accepted only in IDLE; it SHALL be ignored in all other states, with no queuing.
REQ-020 If start is accepted at cycle N, then:
- pix_rd_en SHALL be 1 with pix_addr=0 at cycle N+1.
- led_data SHALL first rise at cycle N+3.
REQ-021 Per channel, scaled value SHALL be (c*(brightness+1))>>8, 16-bit product, truncating.
- brightness=255 SHALL leave the value unchanged.
- brightness=0 SHALL yield c>>8 = 0.
REQ-022 Each 24-bit word SHALL be serialised MSB first: {G,R,B} if order_rgb=0, {R,G,B} if 1.
REQ-023 Each bit SHALL be BIT_CYC cycles: led_data high for T1H_CYC (bit=1) or T0H_CYC (bit=0), then low for the remainder.
REQ-024 Prefetch: during bit 0 of pixel k<NUM_LEDS-1, the block SHALL issue pix_rd_en with pix_addr=k+1 and hold the scaled word in a staging register.
- Consecutive pixels SHALL be emitted with zero gap clocks.
REQ-025 pix_rd_en SHALL be asserted exactly NUM_LEDS times per frame.
REQ-026 NUM_LEDS=1 SHALL send one pixel, with no prefetch strobe.
REQ-027 LATCH SHALL hold led_data low for RST_CYC cycles; frame_done SHALL pulse in the last LATCH cycle, and busy SHALL fall on the next cycle.
REQ-028 pix_addr SHALL wrap to 0 only at a new frame and SHALL never exceed NUM_LEDS-1.
REQ-029 brightness and order_rgb changes mid-frame SHALL not affect the current frame.

Reset
REQ-030 When sys_rst is asserted, regardless of state, the block SHALL immediately (asynchronously) take these values:
- state IDLE
- led_data=0, busy=0, frame_done=0, pix_rd_en=0, pix_addr=0
- all counters, staging and shift registers 0
REQ-031 Reset mid-frame SHALL abort the frame; after release, the first start SHALL begin from pixel 0.

Structure
REQ-032 Package ws2812_pkg SHALL hold:
- the FSM state enumeration
- default timing constants for 50 MHz (T0H 20, T1H 40, BIT 63, RST 15000)
- the color-order encoding
REQ-033 The bit-period timer and the high/low decision SHALL be a sub-module ws2812_bit_tx (inputs: load, bit; outputs: dout, bit_done), instantiated once.

Verification
REQ-034 NUM_LEDS=2, brightness=255, order_rgb=0, pixels {FF0000, 00FF00}; start at cycle 0 -> led_data rises at cycle 3.
- Pixel 0 = 8 zero-bits, 8 one-bits, 8 zero-bits (high 20/40/20).
- Pixel 1 follows with no gap; frame_done pulses at 3+48*63+15000-1.
REQ-035 order_rgb=1 with the same pixels -> pixel 0 sends 8 one-bits first.
REQ-036 brightness=127, pixel 808080, GRB -> each byte = 0x40.
REQ-037 start re-pulsed during SEND and during LATCH -> ignored; exactly 2 pix_rd_en per frame.
REQ-038 sys_rst pulsed mid-pixel 1 -> led_data=0 and busy=0 within the reset cycle; the next start reads pix_addr=0.
REQ-039 NUM_LEDS=1, T0H 2, T1H 4, BIT 6, RST 10 -> 24 bits, 1 strobe, frame_done exactly at cycle 3+144+10-1.
